rtc_access_scheduler: RTL
=========================

Name: rtc_access_scheduler

Overview:
- Sequences all accesses to the RTC bus-cycle engine. Runs periodic 11-register read bursts and one-byte user writes (time set), one at a time.
- Arbitrates between the refresh source and the write requester. Issues one bus cycle at a time and waits for completion.
- Tells the register bank which of the 11 capture slots to load.
- Sits between the refresh timer / set-time logic and the bus-cycle engine plus register bank.

Parameters:
- N_REGS, 11, registers per read burst; slot indices 0..N_REGS-1.
- TIMEOUT, 255, max clk cycles to wait for bus_done before abort.
- Address table (fixed, slot→addr): 0:0x21, 1:0x22, 2:0x23, 3:0x24, 4:0x25, 5:0x26, 6:0x27, 7:0x41, 8:0x42, 9:0x43, 10:0xF0.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- refresh_tick  in  1  one-cycle pulse requesting a read burst
- wr_req  in  1  write request, sampled when wr_ready=1
- wr_sel  in  4  slot index to write (0..10)
- wr_data  in  8  byte to write
- wr_ready  out  1  1 = no write pending, new wr_req accepted
- wr_ack  out  1  one-cycle pulse when the write bus cycle completes
- bus_start  out  1  one-cycle pulse launching a bus cycle
- bus_rd_n  out  1  0 = read cycle, 1 = write cycle; held through the cycle
- bus_addr  out  8  RTC address; held through the cycle
- bus_wdata  out  8  write byte; held through the cycle
- bus_done  in  1  one-cycle pulse from engine, cycle finished
- slot_valid  out  1  one-cycle pulse: bank loads read data into slot_idx
- slot_idx  out  4  capture slot index
- burst_busy  out  1  1 while a read burst is in progress
- burst_done  out  1  one-cycle pulse after the last slot of a burst
- timeout_err  out  1  one-cycle pulse when a cycle is aborted

Behaviour:
- Reset (async assert): state IDLE; idx=0; rd_pend=0; wr_pend=0; wdog=0; all pulse outputs 0; bus_rd_n=1; bus_addr=0; bus_wdata=0; slot_idx=0; wr_ready=1.
- Release is synchronous to clk.
- Request latching:
  - refresh_tick sets rd_pend in any state. Multiple ticks coalesce to one pending burst.
  - rd_pend clears on IDLE→RD_ISSUE.
  - wr_req with wr_ready=1 and wr_sel≤10 latches sel/data and sets wr_pend; wr_ready=0 next cycle.
  - wr_req with wr_sel>10 is ignored.
  - wr_req while wr_ready=0 is ignored.
  - wr_pend clears with wr_ack.
- IDLE: wr_pend → WR_ISSUE. Otherwise rd_pend → RD_ISSUE with idx=0. Write wins a simultaneous request.
- RD_ISSUE (1 cycle): bus_start=1, bus_rd_n=0, bus_addr=table[idx], burst_busy=1 → RD_WAIT.
- RD_WAIT:
  - bus_done → next cycle slot_valid=1, slot_idx=idx.
  - Then if idx=N_REGS-1 → DONE; otherwise idx+1 and → RD_ISSUE.
  - Per-slot latency: bus_done → next bus_start = 2 cycles.
- DONE (1 cycle): burst_done=1, burst_busy drops to 0 → IDLE.
- Writes are never inserted mid-burst. A write pending during a burst runs on the next IDLE, ahead of any re-pended read.
- WR_ISSUE (1 cycle): bus_start=1, bus_rd_n=1, bus_addr=table[sel], bus_wdata=data → WR_WAIT.
- WR_WAIT: bus_done → wr_ack=1 next cycle → IDLE.
- Watchdog:
  - wdog clears on every ISSUE and counts in the WAIT states.
  - Reaching TIMEOUT without bus_done:
    - timeout_err pulse; → IDLE.
    - Burst aborted: no burst_done, idx=0, burst_busy=0.
    - Aborted write stays pending and is retried.
- bus_done outside a WAIT state is ignored.
- Reset mid-cycle: immediate return to reset values. The engine is reset by the same signal.

Test Plan:
- Single tick, engine answers bus_done 3 cycles after each start → 11 starts with addrs 0x21..0x27,0x41..0x43,0xF0, all bus_rd_n=0; slot_valid for idx 0..10 in order; one burst_done; burst_busy high from first start to DONE.
- wr_req sel=2 data=0x15 while IDLE → bus_start with bus_rd_n=1, addr 0x23, wdata 0x15; wr_ack 1 cycle after bus_done; wr_ready 0 then back to 1.
- wr_req and refresh_tick in same cycle → write cycle first, then full 11-slot burst; a second tick during that burst → exactly one more burst afterwards.
- wr_req sel=4 during a burst at slot 5 → burst completes all 11 slots uninterrupted, then write to 0x25. A second wr_req while wr_ready=0 → ignored.
- Engine withholds bus_done at slot 3 → timeout_err after TIMEOUT cycles; no slot_valid for 3; no burst_done; next tick restarts at slot 0, addr 0x21.
- reset asserted during RD_WAIT slot 7 → all outputs at reset values immediately; after release with no requests → no bus_start.

Source files
------------

// File: rtl/rtc_access_scheduler.sv
// rtc_access_scheduler
// Sequences every access to the RTC bus-cycle engine. It runs 11-register
// read bursts when a refresh is pending and single-byte writes from the
// set-time logic. Only one bus cycle is in flight at a time. A watchdog
// aborts any cycle the engine never finishes.
module rtc_access_scheduler #(
  parameter int N_REGS  = 11,
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       refresh_tick,
  input  logic       wr_req,
  input  logic [3:0] wr_sel,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  output logic       wr_ack,
  output logic       bus_start,
  output logic       bus_rd_n,
  output logic [7:0] bus_addr,
  output logic [7:0] bus_wdata,
  input  logic       bus_done,
  output logic       slot_valid,
  output logic [3:0] slot_idx,
  output logic       burst_busy,
  output logic       burst_done,
  output logic       timeout_err
);

  localparam int         WDOG_W   = $clog2(TIMEOUT + 1);
  localparam logic [3:0] LAST_IDX = 4'(N_REGS - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    RD_NEXT,
    RD_DONE,
    WR_ISSUE,
    WR_WAIT
  } state_t;

  state_t            state;
  logic [3:0]        idx;
  logic              rd_pend;
  logic              wr_pend;
  logic [3:0]        wr_sel_q;
  logic [7:0]        wr_data_q;
  logic [WDOG_W-1:0] wdog;
  logic              wdog_expired;

  // Fixed map from capture slot to RTC register address.
  // NOTE: a case inside a function with a default arm returns a value on every
  // path, so it becomes plain combinational decode and can never infer a latch.
  function automatic logic [7:0] slot_addr(input logic [3:0] slot);
    case (slot)
      4'd0:    slot_addr = 8'h21;
      4'd1:    slot_addr = 8'h22;
      4'd2:    slot_addr = 8'h23;
      4'd3:    slot_addr = 8'h24;
      4'd4:    slot_addr = 8'h25;
      4'd5:    slot_addr = 8'h26;
      4'd6:    slot_addr = 8'h27;
      4'd7:    slot_addr = 8'h41;
      4'd8:    slot_addr = 8'h42;
      4'd9:    slot_addr = 8'h43;
      4'd10:   slot_addr = 8'hF0;
      default: slot_addr = 8'h00;
    endcase
  endfunction

  // The watchdog has reached its last allowed wait cycle without completion.
  assign wdog_expired = (wdog == WDOG_W'(TIMEOUT - 1));

  // Request latching, arbitration and the bus-cycle FSM. All outputs are registered.
  // NOTE: every state update here uses <=. The "next" values computed in one
  // branch must not be seen by other branches within the same clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      idx         <= 4'd0;
      rd_pend     <= 1'b0;
      wr_pend     <= 1'b0;
      wr_sel_q    <= 4'd0;
      wr_data_q   <= 8'h00;
      wdog        <= '0;
      wr_ready    <= 1'b1;
      wr_ack      <= 1'b0;
      bus_start   <= 1'b0;
      bus_rd_n    <= 1'b1;
      bus_addr    <= 8'h00;
      bus_wdata   <= 8'h00;
      slot_valid  <= 1'b0;
      slot_idx    <= 4'd0;
      burst_busy  <= 1'b0;
      burst_done  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      // Single-cycle pulses default low and are raised only where needed.
      bus_start   <= 1'b0;
      slot_valid  <= 1'b0;
      burst_done  <= 1'b0;
      wr_ack      <= 1'b0;
      timeout_err <= 1'b0;

      // Accept a write only when idle-for-writes and the slot exists.
      if (wr_req && wr_ready && (wr_sel <= LAST_IDX)) begin
        wr_sel_q  <= wr_sel;
        wr_data_q <= wr_data;
        wr_pend   <= 1'b1;
        wr_ready  <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (wr_pend) begin
            // A pending write is served before a pending burst.
            state     <= WR_ISSUE;
            bus_start <= 1'b1;
            bus_rd_n  <= 1'b1;
            bus_addr  <= slot_addr(wr_sel_q);
            bus_wdata <= wr_data_q;
            wdog      <= '0;
          end else if (rd_pend) begin
            state      <= RD_ISSUE;
            rd_pend    <= 1'b0;
            idx        <= 4'd0;
            bus_start  <= 1'b1;
            bus_rd_n   <= 1'b0;
            bus_addr   <= slot_addr(4'd0);
            burst_busy <= 1'b1;
            wdog       <= '0;
          end
        end

        RD_ISSUE: state <= RD_WAIT;

        RD_WAIT: begin
          if (bus_done) begin
            slot_valid <= 1'b1;
            slot_idx   <= idx;
            state      <= RD_NEXT;
          end else if (wdog_expired) begin
            // Abandon the whole burst. The next refresh restarts at slot 0.
            timeout_err <= 1'b1;
            idx         <= 4'd0;
            burst_busy  <= 1'b0;
            state       <= IDLE;
          end else begin
            wdog <= wdog + WDOG_W'(1);
          end
        end

        RD_NEXT: begin
          if (idx == LAST_IDX) begin
            burst_done <= 1'b1;
            burst_busy <= 1'b0;
            idx        <= 4'd0;
            state      <= RD_DONE;
          end else begin
            idx       <= idx + 4'd1;
            bus_start <= 1'b1;
            bus_rd_n  <= 1'b0;
            bus_addr  <= slot_addr(idx + 4'd1);
            wdog      <= '0;
            state     <= RD_ISSUE;
          end
        end

        RD_DONE: state <= IDLE;

        WR_ISSUE: state <= WR_WAIT;

        WR_WAIT: begin
          if (bus_done) begin
            wr_ack   <= 1'b1;
            wr_pend  <= 1'b0;
            wr_ready <= 1'b1;
            state    <= IDLE;
          end else if (wdog_expired) begin
            // The write stays pending and is retried from IDLE.
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            wdog <= wdog + WDOG_W'(1);
          end
        end

        default: state <= IDLE;
      endcase

      // A refresh tick in any state leaves one burst pending. It wins over the
      // clear on the IDLE->RD_ISSUE edge, so a tick there is not lost.
      if (refresh_tick) rd_pend <= 1'b1;
    end
  end

endmodule
